ps2_rx_fifo: RTL and testbench

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_byte_fifo.sv | 67 ++++++
 rtl/ps2_rx_fifo.sv | 135 +++++++++++++
 tb/tb_ps2_rx_fifo.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver: FSM state encoding, frame
// geometry and line levels, plus the odd-parity helper.
package ps2_pkg;

  // Receive FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  // Data bits per frame
  localparam int FRAME_BITS = 8;

  // Line levels of the framing bits
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // True when data plus parity bit hold an odd number of ones
  function automatic logic odd_parity_ok(input logic [FRAME_BITS-1:0] d,
                                         input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// First-word fall-through byte FIFO with sticky overflow flag.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise the byte is dropped and overflow is set.
module ps2_byte_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          push,
  input  logic [7:0]                    push_data,
  input  logic                          rd_en,
  input  logic                          ovf_clr,
  output logic [7:0]                    data_out,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          write;
  logic          drop;

  assign valid = (count != '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = rd_en && valid;
  // When full, the pop frees the slot the write pointer already points at
  assign write = push && (!full || pop);
  assign drop  = push && full && !pop;

  // Head byte is shown directly; forced to zero while empty
  assign data_out = valid ? mem[rd_ptr] : 8'h00;

  // Storage write port; contents need no reset because valid gates the output
  always_ff @(posedge clock) begin
    if (write) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and sticky overflow (a set beats a clear)
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (write) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({write, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver feeding a byte FIFO.
// Synchronises the raw pins, detects falling edges of the PS/2 clock, runs
// the frame FSM with an inter-edge timeout, and pushes good bytes.
// Optional macro PS2_PARITY_CHECK_EN: reject frames with even parity.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          ovf_clr,
  output logic [7:0]                    data_out,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(FRAME_BITS);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;
  logic                   clk_prev;
  logic                   fall;

  rx_state_e              state;
  logic [BW-1:0]          bit_cnt;
  logic [FRAME_BITS-1:0]  shift;
  logic                   parity_bit;
  logic [TW-1:0]          timer;
  logic                   frame_ok;
  logic                   push;
  logic                   timed_out;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev && !clk_s;

  // Pin synchronisers and previous-clock register; reset to the idle bus level
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = (data_s == STOP_LEVEL) && odd_parity_ok(shift, parity_bit);
`else
  // Parity is captured but deliberately not judged in this build
  logic unused_parity;
  assign unused_parity = parity_bit;
  assign frame_ok      = (data_s == STOP_LEVEL);
`endif

  // The good byte enters the FIFO at the clock edge closing the stop-edge cycle
  assign push      = fall && (state == ST_STOP) && frame_ok;
  assign timed_out = (state != ST_IDLE) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));

  // Frame FSM with timeout; frame_err is a registered single-cycle pulse
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      timer      <= '0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (timed_out) begin
        state     <= ST_IDLE;
        timer     <= '0;
        frame_err <= 1'b1;
      end else begin
        if (fall || state == ST_IDLE) timer <= '0;
        else                          timer <= timer + TW'(1);
        if (fall) begin
          case (state)
            ST_IDLE: begin
              if (data_s == START_LEVEL) begin
                state   <= ST_DATA;
                bit_cnt <= '0;
              end
            end
            ST_DATA: begin
              shift <= {data_s, shift[FRAME_BITS-1:1]};
              if (bit_cnt == BW'(FRAME_BITS - 1)) state <= ST_PARITY;
              else                                bit_cnt <= bit_cnt + BW'(1);
            end
            ST_PARITY: begin
              parity_bit <= data_s;
              state      <= ST_STOP;
            end
            ST_STOP: begin
              if (!frame_ok) frame_err <= 1'b1;
              state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  ps2_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .resetn   (resetn),
    .push     (push),
    .push_data(shift),
    .rd_en    (rd_en),
    .ovf_clr  (ovf_clr),
    .data_out (data_out),
    .valid    (valid),
    .count    (count),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed vector table, hand-written corner
// sequences, then random frames/reads against a queue-based model.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
  localparam int TMO   = 300;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] data_out;
  logic       valid;
  logic [3:0] count;
  logic       overflow;
  logic       frame_err;

  ps2_rx_fifo #(
    .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .ovf_clr(ovf_clr), .data_out(data_out), .valid(valid),
    .count(count), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int ferr_cnt = 0;
  int last_low = 0;
  int n_pass = 0;
  int n_total = 0;

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) if (frame_err) ferr_cnt <= ferr_cnt + 1;

  // Reference model: plain queue plus sticky flag
  logic [7:0] m_q[$];
  logic       m_ovf = 1'b0;

  typedef struct {
    int         op;       // 0 frame, 1 read, 2 ovf_clr
    logic [7:0] d;
    logic       p;
    logic       s;
    logic [7:0] e_data;
    logic       e_valid;
    int         e_count;
    int         e_ferr;
  } vec_t;

  vec_t tbl[7];

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  // One PS/2 bit; strobe 1/2 pulses rd_en/ovf_clr in the cycle the edge is seen
  task automatic drive_bit(input logic b, input int strobe);
    ps2_data = b;
    tick(5);
    ps2_clk  = 1'b0;
    last_low = cyc;
    if (strobe != 0) begin
      tick(SYNC);
      if (strobe == 1) rd_en = 1'b1; else ovf_clr = 1'b1;
      tick(1);
      rd_en = 1'b0; ovf_clr = 1'b0;
      tick(10 - SYNC - 1);
    end else begin
      tick(10);
    end
    ps2_clk = 1'b1;
    tick(5);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int strobe);
    drive_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 0);
    drive_bit(p, 0);
    drive_bit(s, strobe);
    ps2_data = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic p, input logic s, input int strobe);
    logic ok;
    logic [7:0] junk;
    ok = s;
`ifdef PS2_PARITY_CHECK_EN
    ok = ok && ((^d ^ p) == 1'b1);
`endif
    if (strobe == 2) m_ovf = 1'b0;
    if (strobe == 1 && m_q.size() > 0) junk = m_q.pop_front();
    if (ok) begin
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic do_frame(input logic [7:0] d, input logic p, input logic s, input int strobe);
    send_frame(d, p, s, strobe);
    model_frame(d, p, s, strobe);
  endtask

  task automatic do_read();
    logic [7:0] junk;
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    if (m_q.size() > 0) junk = m_q.pop_front();
  endtask

  task automatic do_clr();
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic check_model(input string tag, input int exp_ferr, input int got_ferr);
    chk({tag, ".data_out"}, data_out, (m_q.size() > 0) ? m_q[0] : 8'h00);
    chk({tag, ".valid"}, valid, m_q.size() > 0);
    chk({tag, ".count"}, count, m_q.size());
    chk({tag, ".overflow"}, overflow, m_ovf);
    chk({tag, ".frame_err"}, got_ferr, exp_ferr);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    bit seen;
    int elapsed;

    // Directed vector table
    tbl[0] = '{0, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b1, 1, 0};
    tbl[1] = '{1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0};
`ifdef PS2_PARITY_CHECK_EN
    tbl[2] = '{0, 8'h1C, 1'b1, 1'b1, 8'h00, 1'b0, 0, 1};
`else
    tbl[2] = '{0, 8'h1C, 1'b1, 1'b1, 8'h1C, 1'b1, 1, 0};
`endif
    tbl[3] = '{1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0};
    tbl[4] = '{0, 8'h3A, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1};
    tbl[5] = '{0, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1, 0};
    tbl[6] = '{1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0};

    // Reset state (checked while reset is held)
    tick(3);
    chk("reset.data_out", data_out, 0);
    chk("reset.valid", valid, 0);
    chk("reset.count", count, 0);
    chk("reset.overflow", overflow, 0);
    chk("reset.frame_err", frame_err, 0);
    resetn = 1'b1;
    tick(3);

    for (int i = 0; i < 7; i++) begin
      f0 = ferr_cnt;
      if (tbl[i].op == 0) do_frame(tbl[i].d, tbl[i].p, tbl[i].s, 0);
      else do_read();
      tick(2);
      chk($sformatf("vec%0d.data_out", i), data_out, tbl[i].e_data);
      chk($sformatf("vec%0d.valid", i), valid, tbl[i].e_valid);
      chk($sformatf("vec%0d.count", i), count, tbl[i].e_count);
      chk($sformatf("vec%0d.frame_err", i), ferr_cnt - f0, tbl[i].e_ferr);
      $display("vec %0d op=%0d d=%02h -> data_out=%02h valid=%0b count=%0d", i, tbl[i].op, tbl[i].d, data_out, valid, count);
    end

    // Overflow: 9 bytes into 8 entries, drain 0x01..0x08
    for (int b = 1; b <= 9; b++) do_frame(8'(b), good_par(8'(b)), 1'b1, 0);
    chk("ovf.count", count, 8);
    chk("ovf.overflow", overflow, 1);
    chk("ovf.head", data_out, 8'h01);
    $display("ovf fill: count=%0d overflow=%0b head=%02h", count, overflow, data_out);
    for (int b = 1; b <= 8; b++) begin
      chk($sformatf("drain%0d", b), data_out, b);
      do_read();
    end
    chk("drain.valid", valid, 0);
    chk("drain.data_out", data_out, 0);
    do_clr();
    chk("ovf_clr", overflow, 0);
    $display("ovf drain done: overflow=%0b", overflow);

    // Full FIFO, push and pop in the same cycle
    for (int b = 1; b <= 8; b++) do_frame(8'(b), good_par(8'(b)), 1'b1, 0);
    do_frame(8'h0A, good_par(8'h0A), 1'b1, 1);
    tick(1);
    chk("fullpp.count", count, 8);
    chk("fullpp.head", data_out, 8'h02);
    chk("fullpp.overflow", overflow, 0);
    $display("full push+pop: count=%0d head=%02h", count, data_out);
    for (int k = 0; k < 7; k++) do_read();
    chk("fullpp.tail", data_out, 8'h0A);
    do_read();
    // Drop with ovf_clr in the same cycle: set wins
    for (int b = 1; b <= 8; b++) do_frame(8'(b), good_par(8'(b)), 1'b1, 0);
    do_frame(8'h77, good_par(8'h77), 1'b1, 2);
    chk("setwins.overflow", overflow, 1);
    chk("setwins.count", count, 8);
    $display("set vs clear: overflow=%0b", overflow);
    for (int k = 0; k < 8; k++) do_read();
    do_clr();

    // Timeout: start + 4 data bits then idle bus
    f0 = ferr_cnt;
    drive_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 0);
    ps2_data = 1'b1;
    seen = 0;
    for (int k = 0; k < TMO + 40 && !seen; k++) begin
      if (frame_err) seen = 1;
      else tick(1);
    end
    elapsed = cyc - last_low;
    chk("tmo.seen", seen, 1);
    chk("tmo.window", (elapsed >= TMO && elapsed <= TMO + 6), 1);
    tick(3);
    chk("tmo.pulses", ferr_cnt - f0, 1);
    chk("tmo.count", count, 0);
    $display("timeout: frame_err after %0d cycles", elapsed);
    do_frame(8'hF0, 1'b1, 1'b1, 0);
    tick(1);
    chk("tmo.next", data_out, 8'hF0);
    chk("tmo.next_count", count, 1);
    do_read();

    // Reset mid-frame
    do_frame(8'h33, good_par(8'h33), 1'b1, 0);
    drive_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 0);
    ps2_data = 1'b1;
    resetn = 1'b0;
    #1;
    chk("rst.data_out", data_out, 0);
    chk("rst.valid", valid, 0);
    chk("rst.count", count, 0);
    chk("rst.overflow", overflow, 0);
    tick(3);
    resetn = 1'b1;
    m_q.delete();
    m_ovf = 1'b0;
    tick(3);
    do_frame(8'h5A, 1'b1, 1'b1, 0);
    tick(1);
    chk("rst.next", data_out, 8'h5A);
    chk("rst.next_count", count, 1);
    $display("reset mid-frame: next byte=%02h count=%0d", data_out, count);

    // Random traffic against the model
    for (int t = 0; t < 40; t++) begin
      int op;
      logic [7:0] d;
      logic p, s;
      int st, exp_ferr;
      op = $urandom_range(0, 9);
      f0 = ferr_cnt;
      exp_ferr = 0;
      if (op <= 5) begin
        d  = 8'($urandom);
        p  = ($urandom_range(0, 4) == 0) ? ~good_par(d) : good_par(d);
        s  = ($urandom_range(0, 6) != 0);
        st = $urandom_range(0, 2);
        exp_ferr = !s;
`ifdef PS2_PARITY_CHECK_EN
        if (s && (^d ^ p) == 1'b0) exp_ferr = 1;
`endif
        do_frame(d, p, s, st);
        $display("rnd %0d frame d=%02h p=%0b s=%0b st=%0d -> count=%0d ovf=%0b", t, d, p, s, st, count, overflow);
      end else if (op <= 8) begin
        do_read();
        $display("rnd %0d read -> count=%0d head=%02h", t, count, data_out);
      end else begin
        do_clr();
        $display("rnd %0d ovf_clr -> ovf=%0b", t, overflow);
      end
      tick(2);
      check_model($sformatf("rnd%0d", t), exp_ferr, ferr_cnt - f0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
